// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;
    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    // Fetch controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // One queued instruction together with the address it was fetched from
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular-buffer storage for fetched instructions. Pointers wrap naturally
// because DEPTH is a power of two; clr_i empties the buffer and wins over
// push/pop in the same cycle. The head entry is read straight from the
// storage registers so it is visible the cycle after it was written.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  fetch_entry_t data_i,
    output fetch_entry_t data_o,
    output logic         empty_o,
    output logic [4:0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_push = push_i && !full;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = 5'(count_q);

    // Pointer and occupancy bookkeeping; a flush resets everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

    // Entry storage; contents need no reset because count gates validity
    always_ff @(posedge clk) begin
        if (do_push && !clr_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues in-order word fetches under a credit
// limit, queues the returned words with their addresses, and handles
// redirects by flushing and dropping responses still in flight.
// Optional build macro FETCH_BYPASS_EN: an empty queue passes the incoming
// memory word straight to inst/inst_valid in the same cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              inst_ready,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic [4:0]        occupancy
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;          // next address to request
    logic [PC_W-1:0] rsp_pc_q, rsp_pc_d;  // address of next kept response
    logic [4:0]      outst_q, outst_d;    // granted but not yet answered
    logic [4:0]      drop_q, drop_d;      // responses still to discard

    logic            fifo_empty;
    logic [4:0]      fifo_count;
    fetch_entry_t    fifo_head;
    fetch_entry_t    fifo_in;
    logic [5:0]      inflight;
    logic            grant;
    logic            dropping;
    logic            rsp_take;
    logic            bypass;
    logic            push;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credit rule: queued plus in-flight never exceeds the queue depth
    assign inflight  = {1'b0, fifo_count} + {1'b0, outst_q};
    assign imem_req  = (state_q == RUN) && !redirect && (inflight < 6'(DEPTH));
    assign imem_addr = pc_q;
    assign grant     = imem_req && imem_gnt;
    assign dropping  = (drop_q != '0);
    assign rsp_take  = imem_rvalid && !dropping && !redirect;
    assign fifo_in   = '{inst: imem_rdata, pc: rsp_pc_q};
    assign occupancy = fifo_count;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (redirect),
        .push_i  (push),
        .pop_i   (inst_ready && !fifo_empty),
        .data_i  (fifo_in),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Head presentation, optional same-cycle bypass, and queue write enable
    always_comb begin
`ifdef FETCH_BYPASS_EN
        bypass = fifo_empty && imem_rvalid && !dropping && !redirect && (state_q != IDLE);
`else
        bypass = 1'b0;
`endif
        inst_valid = !fifo_empty || bypass;
        inst       = '0;
        inst_pc    = '0;
        if (!fifo_empty) begin
            inst    = fifo_head.inst;
            inst_pc = fifo_head.pc;
        end else if (bypass) begin
            inst    = imem_rdata;
            inst_pc = rsp_pc_q;
        end
        // A bypassed word consumed this cycle never enters the queue
        push = rsp_take && !(bypass && inst_ready);
    end

    // Next-state logic: counters and addresses, then redirect overrides
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        outst_d  = outst_q + 5'(grant) - 5'(imem_rvalid);
        drop_d   = drop_q;
        if (dropping && imem_rvalid) drop_d = drop_q - 5'd1;
        if (grant)    pc_d     = pc_q + PC_INC;
        if (rsp_take) rsp_pc_d = rsp_pc_q + PC_INC;
        if (redirect) begin
            pc_d     = {redirect_pc[PC_W-1:2], 2'b00};
            rsp_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
            drop_d   = outst_d;  // everything still in flight is stale
        end
        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (drop_d != '0) state_d = DRAIN;
            DRAIN:   if (drop_d == '0) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Controller state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a fixed-latency memory model answers grants, the
// stimulus process queues the expected fetch addresses, and a forked
// monitor compares every accepted instruction against that queue.
module tb_fetch_queue;

    localparam logic [31:0] MEM_KEY = 32'h1357_9BDF;
`ifdef FETCH_BYPASS_EN
    localparam int FIRST_VALID = 2;
`else
    localparam int FIRST_VALID = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [4:0]  occupancy;

    int          errors = 0;
    int          checks = 0;
    int          lat = 1;
    logic [31:0] exp_q[$];

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_ready  (inst_ready),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .occupancy   (occupancy)
    );

    always #5 clk = ~clk;

    // Memory: answers each grant exactly lat cycles later, in order
    logic        pv [4];
    logic [31:0] pa [4];
    always @(posedge clk) begin
        logic        hs;
        logic [31:0] ha;
        hs = rst && imem_req && imem_gnt;
        ha = imem_addr;
        #1;
        for (int i = 0; i < 3; i++) begin
            pv[i] = pv[i+1];
            pa[i] = pa[i+1];
        end
        pv[3] = 1'b0;
        if (!rst) begin
            for (int i = 0; i < 4; i++) pv[i] = 1'b0;
        end else if (hs) begin
            pv[lat-1] = 1'b1;
            pa[lat-1] = ha;
        end
        imem_rvalid = pv[0];
        imem_rdata  = pv[0] ? (pa[0] ^ MEM_KEY) : 32'h0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic to_drive();
        @(posedge clk);
        #2;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic monitor();
        logic [31:0] epc;
        forever begin
            @(negedge clk);
            if (rst && inst_valid && inst_ready) begin
                $display("pop pc=%08h inst=%08h", inst_pc, inst);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected: got pc %0h, expected no instruction", inst_pc);
                end else begin
                    epc = exp_q.pop_front();
                    check("mon_pc", inst_pc, epc);
                    check("mon_inst", inst, epc ^ MEM_KEY);
                end
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        to_drive();
        while (exp_q.size() != 0 && n < 60) begin
            to_drive();
            n++;
        end
        check({name, "_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_occ"}, 32'(occupancy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          grants;
        logic [31:0] d_addr [3];
        d_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        fork
            monitor();
        join_none

        // Reset values
        repeat (2) @(posedge clk);
        to_sample();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_occ", 32'(occupancy), 32'd0);

        // Streaming fetch from reset with a 1-cycle memory
        for (int k = 0; k < 8; k++) exp_q.push_back(32'(4 * k));
        to_drive();
        rst = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            to_drive();
            to_sample();
            check("A_req", 32'(imem_req), 32'd1);
            check("A_addr", imem_addr, 32'(4 * (k - 1)));
            check("A_valid", 32'(inst_valid), 32'(k >= FIRST_VALID));
        end
        to_drive();
        imem_gnt = 1'b0;
        wait_drain("A");

        // Stalled pipeline: credit limit stops at 4 requests
        to_drive();
        imem_gnt = 1'b1; inst_ready = 1'b0;
        grants = 0;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) to_drive();
            to_sample();
            if (imem_req && imem_gnt) grants++;
        end
        check("B_grants", 32'(grants), 32'd4);
        check("B_occ", 32'(occupancy), 32'd4);
        check("B_req", 32'(imem_req), 32'd0);
        for (int k = 0; k < 4; k++) exp_q.push_back(32'h20 + 32'(4 * k));
        to_drive();
        inst_ready = 1'b1; imem_gnt = 1'b0;
        to_sample();
        check("B_hold", 32'(imem_req), 32'd0);
        to_drive();
        to_sample();
        check("B_resume", 32'(imem_req), 32'd1);
        check("B_addr", imem_addr, 32'h30);
        wait_drain("B");

        // Redirect with two requests outstanding (3-cycle memory)
        to_drive();
        lat = 3; imem_gnt = 1'b1; inst_ready = 1'b1;
        to_sample();
        check("C_addr0", imem_addr, 32'h30);
        to_drive();
        to_sample();
        check("C_addr1", imem_addr, 32'h34);
        to_drive();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        to_sample();
        check("C_req_redir", 32'(imem_req), 32'd0);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        for (int k = 4; k <= 8; k++) begin
            to_drive();
            redirect = 1'b0;
            if (k == 8) imem_gnt = 1'b0;
            to_sample();
            check("C_valid", 32'(inst_valid), 32'd0);
            if (k <= 7) check("C_req", 32'(imem_req), 32'(k >= 6));
            if (k == 6) check("C_addr_new", imem_addr, 32'h100);
            if (k == 7) check("C_addr_next", imem_addr, 32'h104);
        end
        wait_drain("C");

        // Address wrap after redirect near the top of memory
        to_drive();
        lat = 1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; imem_gnt = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(d_addr[k]);
        to_sample();
        check("D_req_redir", 32'(imem_req), 32'd0);
        for (int k = 0; k < 3; k++) begin
            to_drive();
            redirect = 1'b0;
            to_sample();
            check("D_req", 32'(imem_req), 32'd1);
            check("D_addr", imem_addr, d_addr[k]);
        end
        to_drive();
        imem_gnt = 1'b0;
        wait_drain("D");

        // Push and pop together at occupancy 2
        for (int k = 1; k <= 3; k++) exp_q.push_back(32'(4 * k));
        to_drive();
        inst_ready = 1'b0; imem_gnt = 1'b1;
        to_sample();
        to_drive();
        to_sample();
        to_drive();
        to_sample();
        to_drive();
        imem_gnt = 1'b0; inst_ready = 1'b1;
        to_sample();
        check("E_occ_before", 32'(occupancy), 32'd2);
        to_drive();
        inst_ready = 1'b0;
        to_sample();
        check("E_occ_after", 32'(occupancy), 32'd2);
        check("E_head", inst_pc, 32'h8);
        to_drive();
        inst_ready = 1'b1;
        wait_drain("E");

        // Asynchronous reset with 3 queued entries and 1 in flight
        to_drive();
        lat = 2; inst_ready = 1'b0; imem_gnt = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) to_drive();
            if (k == 5) imem_gnt = 1'b0;
            to_sample();
        end
        check("F_occ", 32'(occupancy), 32'd3);
        check("F_valid", 32'(inst_valid), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("F_req", 32'(imem_req), 32'd0);
        check("F_addr", imem_addr, 32'h0);
        check("F_valid_rst", 32'(inst_valid), 32'd0);
        check("F_inst", inst, 32'h0);
        check("F_pc", inst_pc, 32'h0);
        check("F_occ_rst", 32'(occupancy), 32'd0);
        to_drive();
        to_drive();
        rst = 1'b1; lat = 1; imem_gnt = 1'b1; inst_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        for (int k = 0; k < 2; k++) begin
            to_drive();
            to_sample();
            check("F_restart_req", 32'(imem_req), 32'd1);
            check("F_restart_addr", imem_addr, 32'(4 * k));
        end
        to_drive();
        imem_gnt = 1'b0;
        wait_drain("F");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port imem_req, output, 1, fetch request to instruction memory.
REQ-006 SHALL have port imem_addr, output, 32, word-aligned fetch address.
REQ-007 SHALL have port imem_gnt, input, 1, memory accepts the request this cycle.
REQ-008 SHALL have port imem_rvalid, input, 1, read data valid; responses are in order, at most one per cycle, at least one cycle after grant.
REQ-009 SHALL have port imem_rdata, input, 32, instruction word.
REQ-010 SHALL have port redirect, input, 1, flush the queue and restart fetch.
REQ-011 SHALL have port redirect_pc, input, 32, new fetch address; bits [1:0] ignored.
REQ-012 SHALL have port inst_ready, input, 1, pipeline can take an instruction (driven from IF_IDWrite).
REQ-013 SHALL have port inst_valid, output, 1, head entry valid.
REQ-014 SHALL have port inst, output, 32, head instruction.
REQ-015 SHALL have port inst_pc, output, 32, address of head instruction.
REQ-016 SHALL have port occupancy, output, 5, current number of queued entries.

Function
REQ-017 SHALL run FSM IDLE -> RUN one cycle after reset release; RUN -> DRAIN on redirect with outstanding requests, RUN -> RUN on redirect with none; DRAIN -> RUN when the drop counter reaches 0.
REQ-018 SHALL assert imem_req only in RUN, with no redirect this cycle, and only when count + outstanding < DEPTH (credit rule).
REQ-019 SHALL, on imem_req && imem_gnt, increment pc by 4 modulo 2^32 (FFFF_FFFC wraps to 0000_0000) and increment outstanding.
REQ-020 SHALL push {imem_rdata, pc of that request} on imem_rvalid when not dropping; push and pop in the same cycle SHALL leave count unchanged.
REQ-021 SHALL pop the head when inst_valid && inst_ready; inst/inst_pc SHALL be registered outputs, with 1-cycle latency from rvalid to inst_valid.
REQ-022 SHALL, on redirect, clear the queue, load pc with {redirect_pc[31:2],2'b00}, and set the drop counter to outstanding including any request granted in that same cycle.
REQ-023 SHALL discard responses while the drop counter > 0, decrementing once per rvalid; no new requests in DRAIN.
REQ-024 SHALL give redirect priority over simultaneous push, pop and grant.
REQ-025 SHALL never overflow: a push with count == DEPTH is impossible under REQ-018; an empty queue SHALL hold inst_valid = 0.

Reset
REQ-026 SHALL, while rst = 0, force state IDLE, pc = RESET_PC, count/outstanding/drop = 0, imem_req = 0, imem_addr = RESET_PC, inst_valid = 0, inst = 0, inst_pc = 0, occupancy = 0.
REQ-027 SHALL, on reset mid-operation, discard all in-flight requests; memory is reset by the same rst.

Configuration
REQ-028 SHALL, with FETCH_BYPASS_EN defined, present imem_rdata combinationally on inst/inst_valid when the queue is empty and not dropping (0-cycle latency; the entry is not stored if popped the same cycle); without it, behaviour is per REQ-021.

Structure
REQ-029 SHALL take INST_W = 32, PC_W = 32, PC_INC = 4 and the FSM state enum (IDLE, RUN, DRAIN) from shared package fetch_pkg.
REQ-030 SHALL implement storage in sub-module fetch_fifo (circular buffer, wrapping read/write pointers, count).

Verification
REQ-031 Reset release, gnt = 1, 1-cycle rvalid, inst_ready = 1 -> imem_addr 0,4,8,... and inst_pc 0,4,8 with inst_valid steady from cycle 3.
REQ-032 inst_ready = 0 for 10 cycles -> exactly 4 requests issued, occupancy = 4, imem_req = 0 until the first pop.
REQ-033 Redirect to 32'h0000_0103 with 2 outstanding -> next 2 rvalids dropped, next imem_addr = 0000_0100, inst_valid = 0 until the new data arrives.
REQ-034 redirect_pc = FFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 rst low with 3 entries and 1 outstanding -> all outputs at reset values immediately (asynchronous), and fetch restarts at RESET_PC.
REQ-036 Simultaneous push and pop at occupancy 2 -> occupancy remains 2 and order is preserved; with FETCH_BYPASS_EN, empty queue -> inst equals imem_rdata in the same cycle.
